mem_bus_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between the CPU instruction-fetch port and the mem-stage data port.
- Three-state FSM with registered memory-side outputs and one-cycle ack pulses.
- Data requests win by default; a starvation counter guarantees forward progress for fetch.
- A watchdog terminates hung transactions with an error response; stall_req_o feeds pipeline stall control.

---
 rtl/mem_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-port, variable-latency memory between the CPU
// instruction-fetch port (i_*) and the mem-stage data port (d_*).
//
// Transaction flow (IDLE -> BUSY -> RESP):
//   IDLE : requests are sampled; the winner's address/data/strobes are
//          captured into the registered m_* outputs and m_ce is raised.
//   BUSY : m_* held stable while waiting for m_ready. A watchdog ends the
//          transaction with an error if m_ready never arrives.
//   RESP : the owner's one-cycle ack pulse (with err_o on a timeout).
//
// Data requests win by default. A starvation counter forces a fetch grant
// after STARVE_MAX consecutive data grants that were made while a fetch
// was waiting.
//
// Parameters:
//   ADDR_W      - address width
//   DATA_W      - data width
//   TIMEOUT_CYC - BUSY cycles allowed before error termination (>=1)
//   STARVE_MAX  - data grants with fetch pending before fetch is forced (>=1)
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   i_req/i_addr     - fetch request (held until i_ack) and address
//   i_rdata/i_ack    - fetch read data and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_sel
//                    - data request (held until d_ack), write flag,
//                      address, write data, byte enables
//   d_rdata/d_ack    - data read result and one-cycle completion pulse
//   err_o            - high together with the ack of a timed-out transaction
//   m_ce/m_we/m_addr/m_wdata/m_sel
//                    - registered memory request outputs
//   m_rdata/m_ready  - memory read data and completion strobe
//   stall_req_o      - a port has a request that is not being acked now
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_sel,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              err_o,
    // memory side
    output logic              m_ce,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_sel,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    // pipeline stall control
    output logic              stall_req_o
);

    localparam int TCNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [TCNT_W-1:0]   TCNT_LAST  = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // owner encoding: 1 = data port, 0 = fetch port
    state_t              state_q,   state_d;
    logic                owner_q,   owner_d;
    logic [TCNT_W-1:0]   tcnt_q,    tcnt_d;
    logic [STARVE_W-1:0] starve_q,  starve_d;
    logic                m_ce_q,    m_ce_d;
    logic                m_we_q,    m_we_d;
    logic [ADDR_W-1:0]   m_addr_q,  m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [3:0]          m_sel_q,   m_sel_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ack_q,   i_ack_d;
    logic                d_ack_q,   d_ack_d;
    logic                err_q,     err_d;

    logic                grant_data_s;

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        tcnt_d       = tcnt_q;
        starve_d     = starve_q;
        m_ce_d       = m_ce_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_sel_d      = m_sel_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;
        grant_data_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    // Data wins unless a waiting fetch has been passed over
                    // STARVE_MAX times in a row.
                    grant_data_s = d_req && !(i_req && (starve_q == STARVE_LIM));
                    owner_d      = grant_data_s;
                    m_ce_d       = 1'b1;
                    tcnt_d       = '0;
                    state_d      = ST_BUSY;
                    if (grant_data_s) begin
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_sel_d   = d_sel;
                        // Only grants that bypass a waiting fetch count.
                        if (i_req && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end else begin
                            starve_d = starve_q;
                        end
                    end else begin
                        m_we_d    = 1'b0;
                        m_addr_d  = i_addr;
                        m_wdata_d = '0;
                        m_sel_d   = 4'b1111;
                        starve_d  = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUSY: begin
                // m_ready takes precedence over an expiring watchdog.
                if (m_ready) begin
                    if (owner_q) begin
                        d_ack_d = 1'b1;
                        // A write leaves the last read result in place.
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_rdata;
                    end
                    m_ce_d  = 1'b0;
                    m_we_d  = 1'b0;
                    state_d = ST_RESP;
                end else if (tcnt_q == TCNT_LAST) begin
                    err_d = 1'b1;
                    if (owner_q) begin
                        d_ack_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = '0;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = '0;
                    end
                    m_ce_d  = 1'b0;
                    m_we_d  = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end

            ST_RESP: begin
                // Ack pulse is on the outputs this cycle; requests ignored.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                m_ce_d  = 1'b0;
                m_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            tcnt_q    <= '0;
            starve_q  <= '0;
            m_ce_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_sel_q   <= 4'b0000;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            tcnt_q    <= tcnt_d;
            starve_q  <= starve_d;
            m_ce_q    <= m_ce_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_sel_q   <= m_sel_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
        end
    end

    assign m_ce    = m_ce_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_sel   = m_sel_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign err_o   = err_q;

    // A port stalls the pipeline while it requests and is not being acked.
    assign stall_req_o = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;
    localparam int STARVE_MAX  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_sel;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              err_o;
    logic              m_ce;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_sel;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;
    logic              stall_req_o;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_sel(d_sel), .d_rdata(d_rdata), .d_ack(d_ack), .err_o(err_o),
        .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_sel(m_sel), .m_rdata(m_rdata), .m_ready(m_ready),
        .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick;
        @(negedge clk);
    endtask

    // Returns at the falling edge where rst was released: that cycle is
    // the first IDLE sampling cycle (cycle 0 of each scenario).
    task automatic do_reset;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_sel = 4'h0;
        m_ready = 1'b0; m_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({m_ce, m_we, i_ack, d_ack, err_o, stall_req_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {m_ce, m_we, i_ack, d_ack, err_o, stall_req_o});
        end
        checks++;
        if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_sel !== 4'h0) begin
            errors++;
            $display("FAIL reset_mbus: got addr=%h wdata=%h sel=%h expected zeros", m_addr, m_wdata, m_sel);
        end
        checks++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got i=%h d=%h expected zeros", i_rdata, d_rdata);
        end
    endtask

    task automatic test_single_fetch;
        do_reset();
        i_req = 1'b1; i_addr = 32'h0000_0040;
        #1;
        checks++;
        if (stall_req_o !== 1'b1) begin
            errors++; $display("FAIL fetch_stall_c0: got %b expected 1", stall_req_o);
        end
        tick(); // cycle 1
        checks++;
        if (m_ce !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h40 || m_sel !== 4'hf) begin
            errors++;
            $display("FAIL fetch_issue: got ce=%b we=%b addr=%h sel=%h expected 1 0 00000040 f", m_ce, m_we, m_addr, m_sel);
        end
        checks++;
        if (stall_req_o !== 1'b1 || i_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_c1: got stall=%b ack=%b expected 1 0", stall_req_o, i_ack);
        end
        m_ready = 1'b1; m_rdata = 32'h3C01_0001;
        tick(); // cycle 2
        m_ready = 1'b0; m_rdata = 32'h0;
        checks++;
        if (i_ack !== 1'b1 || d_ack !== 1'b0 || err_o !== 1'b0 || i_rdata !== 32'h3C01_0001) begin
            errors++;
            $display("FAIL fetch_ack: got ack=%b dack=%b err=%b rdata=%h expected 1 0 0 3c010001", i_ack, d_ack, err_o, i_rdata);
        end
        checks++;
        if (stall_req_o !== 1'b0 || m_ce !== 1'b0) begin
            errors++; $display("FAIL fetch_c2: got stall=%b ce=%b expected 0 0", stall_req_o, m_ce);
        end
        i_req = 1'b0;
        tick(); // cycle 3
        checks++;
        if (i_ack !== 1'b0 || i_rdata !== 32'h3C01_0001) begin
            errors++; $display("FAIL fetch_hold: got ack=%b rdata=%h expected 0 3c010001", i_ack, i_rdata);
        end
    endtask

    task automatic test_collision;
        do_reset();
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_sel = 4'b0011;
        m_ready = 1'b1; m_rdata = 32'h1122_3344;  // memory always ready
        tick(); // cycle 1
        checks++;
        if (m_ce !== 1'b1 || m_we !== 1'b1 || m_sel !== 4'b0011 || m_addr !== 32'h100 || m_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL coll_data_issue: got ce=%b we=%b sel=%b addr=%h wdata=%h expected 1 1 0011 00000100 deadbeef",
                     m_ce, m_we, m_sel, m_addr, m_wdata);
        end
        tick(); // cycle 2
        checks++;
        if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL coll_data_ack: got dack=%b iack=%b drdata=%h expected 1 0 00000000", d_ack, i_ack, d_rdata);
        end
        d_req = 1'b0;
        tick(); // cycle 3 (IDLE, m_ready ignored)
        checks++;
        if (m_ce !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
            errors++; $display("FAIL coll_idle: got ce=%b iack=%b dack=%b expected 0 0 0", m_ce, i_ack, d_ack);
        end
        tick(); // cycle 4
        checks++;
        if (m_ce !== 1'b1 || m_we !== 1'b0 || m_sel !== 4'hf || m_addr !== 32'h200) begin
            errors++;
            $display("FAIL coll_fetch_issue: got ce=%b we=%b sel=%h addr=%h expected 1 0 f 00000200", m_ce, m_we, m_sel, m_addr);
        end
        tick(); // cycle 5
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h1122_3344) begin
            errors++; $display("FAIL coll_fetch_ack: got ack=%b rdata=%h expected 1 11223344", i_ack, i_rdata);
        end
        i_req = 1'b0; m_ready = 1'b0;
        tick();
    endtask

    task automatic test_starvation;
        string seq;
        int    n_dack;
        int    n_iack;
        logic  prev_ce;
        do_reset();
        i_req = 1'b1; i_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800; d_sel = 4'hf;
        m_ready = 1'b1; m_rdata = 32'h0;
        seq = ""; n_dack = 0; n_iack = 0; prev_ce = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (m_ce && !prev_ce) begin
                if (m_addr === 32'h800)      seq = {seq, "D"};
                else if (m_addr === 32'h400) seq = {seq, "I"};
                else                         seq = {seq, "?"};
            end
            prev_ce = m_ce;
            if (d_ack === 1'b1) n_dack++;
            if (i_ack === 1'b1) begin
                n_iack++;
                i_req = 1'b0;
            end
        end
        checks++;
        if (seq != "DDDDID") begin
            errors++; $display("FAIL starve_order: got %s expected DDDDID", seq);
        end
        checks++;
        if (n_dack != 5 || n_iack != 1) begin
            errors++; $display("FAIL starve_acks: got d=%0d i=%0d expected 5 1", n_dack, n_iack);
        end
        d_req = 1'b0; m_ready = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_timeout;
        int n_ce;
        int n_ack;
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_sel = 4'hf;
        m_ready = 1'b1; m_rdata = 32'hCAFE_F00D;
        tick(); // 1
        tick(); // 2
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'hCAFE_F00D || err_o !== 1'b0) begin
            errors++; $display("FAIL tmo_pre_read: got ack=%b rdata=%h err=%b expected 1 cafef00d 0", d_ack, d_rdata, err_o);
        end
        d_req = 1'b0; m_ready = 1'b0;
        tick(); // 3 IDLE
        d_req = 1'b1; d_addr = 32'h304; m_rdata = 32'h1234_5678;
        n_ce = 0; n_ack = 0;
        for (int k = 0; k < TIMEOUT_CYC; k++) begin
            tick(); // cycles 4..19
            if (m_ce === 1'b1) n_ce++;
            if (d_ack !== 1'b0 || err_o !== 1'b0) n_ack++;
        end
        checks++;
        if (n_ce != TIMEOUT_CYC || n_ack != 0) begin
            errors++; $display("FAIL tmo_busy: got ce_cycles=%0d early_acks=%0d expected %0d 0", n_ce, n_ack, TIMEOUT_CYC);
        end
        tick(); // 20
        checks++;
        if (m_ce !== 1'b0 || d_ack !== 1'b1 || err_o !== 1'b1 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL tmo_resp: got ce=%b ack=%b err=%b rdata=%h expected 0 1 1 00000000", m_ce, d_ack, err_o, d_rdata);
        end
        d_req = 1'b0;
        tick(); // 21 IDLE
        checks++;
        if (err_o !== 1'b0 || d_ack !== 1'b0) begin
            errors++; $display("FAIL tmo_err_pulse: got err=%b ack=%b expected 0 0", err_o, d_ack);
        end
        d_req = 1'b1; d_addr = 32'h308; m_ready = 1'b1; m_rdata = 32'h0BAD_CAFE;
        tick(); // 22
        checks++;
        if (m_ce !== 1'b1 || m_addr !== 32'h308) begin
            errors++; $display("FAIL tmo_next_issue: got ce=%b addr=%h expected 1 00000308", m_ce, m_addr);
        end
        tick(); // 23
        checks++;
        if (d_ack !== 1'b1 || err_o !== 1'b0 || d_rdata !== 32'h0BAD_CAFE) begin
            errors++; $display("FAIL tmo_next_ack: got ack=%b err=%b rdata=%h expected 1 0 0badcafe", d_ack, err_o, d_rdata);
        end
        d_req = 1'b0; m_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        int n_ack;
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'hA5A5_A5A5; d_sel = 4'hf;
        tick(); // 1: first BUSY cycle
        checks++;
        if (m_ce !== 1'b1 || m_we !== 1'b1) begin
            errors++; $display("FAIL rstmid_issue: got ce=%b we=%b expected 1 1", m_ce, m_we);
        end
        tick(); // 2: second BUSY cycle
        rst = 1'b1; d_req = 1'b0;
        tick(); // 3
        checks++;
        if ({m_ce, m_we, i_ack, d_ack, err_o, stall_req_o} !== 6'b0 ||
            m_addr !== 32'h0 || m_wdata !== 32'h0 || m_sel !== 4'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got flags=%b addr=%h wdata=%h sel=%h expected zeros",
                     {m_ce, m_we, i_ack, d_ack, err_o, stall_req_o}, m_addr, m_wdata, m_sel);
        end
        rst = 1'b0; m_ready = 1'b1; m_rdata = 32'h7777_7777;
        n_ack = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (i_ack !== 1'b0 || d_ack !== 1'b0 || m_ce !== 1'b0) n_ack++;
        end
        checks++;
        if (n_ack != 0) begin
            errors++; $display("FAIL rstmid_no_ack: got %0d bad cycles expected 0", n_ack);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_delayed_ready;
        int n_bad;
        int n_ack;
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_sel = 4'b0110;
        tick(); // 1
        d_req = 1'b0; d_addr = 32'hFFFF_0000; d_sel = 4'b1001;
        n_bad = 0;
        for (int k = 0; k < 4; k++) begin  // cycles 1..4
            if (m_ce !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h500 || m_sel !== 4'b0110 || d_ack !== 1'b0) n_bad++;
            if (k == 3) begin
                m_ready = 1'b1; m_rdata = 32'h55AA_55AA;
            end
            tick();
        end
        m_ready = 1'b0;
        checks++;
        if (n_bad != 0) begin
            errors++; $display("FAIL delay_stable: got %0d unstable cycles expected 0", n_bad);
        end
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h55AA_55AA || err_o !== 1'b0) begin
            errors++; $display("FAIL delay_ack: got ack=%b rdata=%h err=%b expected 1 55aa55aa 0", d_ack, d_rdata, err_o);
        end
        n_ack = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (d_ack !== 1'b0 || m_ce !== 1'b0) n_ack++;
        end
        checks++;
        if (n_ack != 0) begin
            errors++; $display("FAIL delay_quiet: got %0d active cycles expected 0", n_ack);
        end
    endtask

    // Transaction-level model: arbitration rule, latency from chosen memory
    // delay, a word-addressed memory array and per-port expected read data.
    task automatic test_random;
        logic [31:0] mem [16];
        logic [31:0] t_addr, t_wdata, t_rdata, exp_i, exp_d;
        logic [3:0]  t_sel, t_idx;
        logic        t_data, t_we, t_err, infl, i_out, d_out;
        logic        exp_iack, exp_dack, exp_err, exp_ce;
        int          g, eff, ack_c, next_free, starve, delay, sel;
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        do_reset();
        exp_i = '0; exp_d = '0; starve = 0; infl = 1'b0; next_free = 0;
        i_out = 1'b0; d_out = 1'b0; g = 0; eff = 0; ack_c = -1; delay = 0;
        t_data = 1'b0; t_we = 1'b0; t_err = 1'b0; t_addr = '0; t_wdata = '0;
        t_rdata = '0; t_sel = 4'h0; t_idx = 4'h0;
        for (int c = 0; c < 2500; c++) begin
            exp_iack = infl && (c == ack_c) && !t_data;
            exp_dack = infl && (c == ack_c) && t_data;
            exp_err  = infl && (c == ack_c) && t_err;
            exp_ce   = infl && (c >= g + 1) && (c <= g + 1 + eff);
            if (exp_iack) exp_i = t_err ? 32'h0 : t_rdata;
            if (exp_dack && !t_we) exp_d = t_err ? 32'h0 : t_rdata;
            checks++;
            if ({i_ack, d_ack, err_o} !== {exp_iack, exp_dack, exp_err}) begin
                errors++; $display("FAIL rnd_ack c=%0d: got %b expected %b", c, {i_ack, d_ack, err_o}, {exp_iack, exp_dack, exp_err});
            end
            checks++;
            if (m_ce !== exp_ce) begin
                errors++; $display("FAIL rnd_ce c=%0d: got %b expected %b", c, m_ce, exp_ce);
            end
            checks++;
            if (i_rdata !== exp_i || d_rdata !== exp_d) begin
                errors++; $display("FAIL rnd_rdata c=%0d: got i=%h d=%h expected i=%h d=%h", c, i_rdata, d_rdata, exp_i, exp_d);
            end
            if (exp_ce) begin
                checks++;
                if (m_addr !== t_addr || m_we !== t_we || m_sel !== t_sel || (t_data && m_wdata !== t_wdata)) begin
                    errors++;
                    $display("FAIL rnd_mbus c=%0d: got addr=%h we=%b sel=%h wdata=%h expected addr=%h we=%b sel=%h wdata=%h",
                             c, m_addr, m_we, m_sel, m_wdata, t_addr, t_we, t_sel, t_wdata);
                end
            end
            if (infl && c == ack_c) begin
                infl = 1'b0; next_free = c + 1;
                if (t_data) begin d_out = 1'b0; d_req = 1'b0; end
                else        begin i_out = 1'b0; i_req = 1'b0; end
            end
            // the owner may abandon its request line mid-transaction
            if (infl && c > g && c < ack_c && $urandom_range(9) == 0) begin
                if (t_data) d_req = 1'b0; else i_req = 1'b0;
            end
            if (!i_out) begin
                i_addr = {26'd0, 4'($urandom), 2'b00};
                if ($urandom_range(9) < 6) begin i_out = 1'b1; i_req = 1'b1; end
            end
            if (!d_out) begin
                d_addr = {26'd0, 4'($urandom), 2'b00};
                d_we = 1'($urandom); d_wdata = $urandom; d_sel = 4'($urandom);
                if ($urandom_range(9) < 6) begin d_out = 1'b1; d_req = 1'b1; end
            end
            m_ready = 1'b0; m_rdata = $urandom;
            if (infl && c >= g + 1 && c <= g + 1 + eff) begin
                if (c == g + 1 + delay) begin
                    m_ready = 1'b1;
                    t_rdata = mem[t_idx];
                    m_rdata = t_rdata;
                    if (t_we) begin
                        for (int b = 0; b < 4; b++)
                            if (t_sel[b]) mem[t_idx][b*8 +: 8] = t_wdata[b*8 +: 8];
                    end
                end
            end else if ($urandom_range(7) == 0) begin
                m_ready = 1'b1;
            end
            if (!infl && c >= next_free && (i_req || d_req)) begin
                t_data = d_req && !(i_req && starve == STARVE_MAX);
                if (t_data) begin
                    t_addr = d_addr; t_we = d_we; t_sel = d_sel; t_wdata = d_wdata;
                    if (i_req && starve < STARVE_MAX) starve++;
                end else begin
                    t_addr = i_addr; t_we = 1'b0; t_sel = 4'hf; t_wdata = '0;
                    starve = 0;
                end
                t_idx = t_addr[5:2];
                sel = $urandom_range(9);
                if (sel < 7)       delay = $urandom_range(4);
                else if (sel == 7) delay = TIMEOUT_CYC - 1;
                else if (sel == 8) delay = TIMEOUT_CYC;
                else               delay = TIMEOUT_CYC + $urandom_range(5);
                eff   = (delay < TIMEOUT_CYC - 1) ? delay : TIMEOUT_CYC - 1;
                t_err = (delay > TIMEOUT_CYC - 1);
                g = c; ack_c = g + 2 + eff; infl = 1'b1;
            end
            #1;
            checks++;
            if (stall_req_o !== ((i_req & ~exp_iack) | (d_req & ~exp_dack))) begin
                errors++;
                $display("FAIL rnd_stall c=%0d: got %b expected %b", c, stall_req_o, (i_req & ~exp_iack) | (d_req & ~exp_dack));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_collision();
        test_starvation();
        test_timeout();
        test_reset_mid();
        test_delayed_ready();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
